// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_ctrl_pkg : opcodes, bus/ALU encodings and control word for the         |
// |                8-bit bus CPU microsequencer.  Rev 1.0                      |
// +----------------------------------------------------------------------------+
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [3:0] {
    BUS_NONE = 4'd0,
    BUS_PC   = 4'd1,
    BUS_A    = 4'd2,
    BUS_ALU  = 4'd3,
    BUS_B    = 4'd4,
    BUS_MEM  = 4'd5,
    BUS_IR   = 4'd6
  } bus_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_SLL = 2'b10,
    ALU_SRL = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic     memory_in;
    logic     ram_in;
    logic     instruction_in;
    logic     reg_a_in;
    logic     reg_b_in;
    logic     out_in;
    logic     advance_pc;
    logic     pc_in;
    logic     flags_in;
    alu_op_e  alu_op;
    bus_sel_e bus_sel;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = '0;

endpackage
`default_nettype wire

// File: rtl/microseq_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | microseq_control_if : datapath-facing signals of the microsequencer.       |
// |                       Rev 1.0                                              |
// +----------------------------------------------------------------------------+
interface microseq_control_if #(
  parameter int OPCODE_W  = 4,
  parameter int STEP_W    = 3,
  parameter int BUS_SEL_W = 4,
  parameter int ALU_OP_W  = 2
);
  logic [OPCODE_W-1:0]  instruction;
  logic                 carry_flag;
  logic                 zero_flag;
  logic                 mem_ready;
  logic                 hlt;
  logic                 memory_in;
  logic                 ram_in;
  logic                 instruction_in;
  logic                 reg_a_in;
  logic                 reg_b_in;
  logic [ALU_OP_W-1:0]  alu_op;
  logic                 out_in;
  logic                 advance_pc;
  logic                 pc_in;
  logic                 flags_in;
  logic [BUS_SEL_W-1:0] bus_selector;
  logic [STEP_W-1:0]    step;
  logic                 illegal_op;

  modport slave (
    input  instruction, carry_flag, zero_flag, mem_ready,
    output hlt, memory_in, ram_in, instruction_in, reg_a_in, reg_b_in, alu_op,
           out_in, advance_pc, pc_in, flags_in, bus_selector, step, illegal_op
  );

  modport master (
    output instruction, carry_flag, zero_flag, mem_ready,
    input  hlt, memory_in, ram_in, instruction_in, reg_a_in, reg_b_in, alu_op,
           out_in, advance_pc, pc_in, flags_in, bus_selector, step, illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/microcode_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | microcode_rom : (opcode, step, flags) -> control word, end-of-sequence,    |
// |                 halt and illegal indications.  Rev 1.0                     |
// +----------------------------------------------------------------------------+
module microcode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [STEP_W-1:0]   step,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output ctrl_word_t          word,
  output logic                last,
  output logic                halt,
  output logic                illegal
);

  logic       w_hi_nz;
  logic [3:0] w_op;
  logic       w_s2, w_s3, w_s4;

  generate
    if (OPCODE_W > 4) begin : g_wide_op
      assign w_hi_nz = |opcode[OPCODE_W-1:4];
    end else begin : g_narrow_op
      assign w_hi_nz = 1'b0;
    end
  endgenerate

  assign w_op = opcode[3:0];
  assign w_s2 = (step == STEP_W'(2));
  assign w_s3 = (step == STEP_W'(3));
  assign w_s4 = (step == STEP_W'(4));

  // Steps past the end of any sequence decode to an idle word flagged as last.
  always_comb begin
    word    = CTRL_IDLE;
    last    = 1'b1;
    halt    = 1'b0;
    illegal = 1'b0;
    if (step == STEP_W'(0)) begin
      word.bus_sel   = BUS_PC;
      word.memory_in = 1'b1;
      last           = 1'b0;
    end else if (step == STEP_W'(1)) begin
      word.bus_sel        = BUS_MEM;
      word.instruction_in = 1'b1;
      word.advance_pc     = 1'b1;
      last                = 1'b0;
    end else if (w_hi_nz) begin
      illegal = w_s2;
    end else begin
      case (w_op)
        OP_NOP: ;
        OP_LDA, OP_STA: begin
          if (w_s2) begin
            word.bus_sel   = BUS_IR;
            word.memory_in = 1'b1;
            last           = 1'b0;
          end else if (w_s3) begin
            if (w_op == OP_LDA) begin
              word.bus_sel  = BUS_MEM;
              word.reg_a_in = 1'b1;
            end else begin
              word.bus_sel = BUS_A;
              word.ram_in  = 1'b1;
            end
          end
        end
        OP_ADD, OP_SUB: begin
          if (w_s2) begin
            word.bus_sel   = BUS_IR;
            word.memory_in = 1'b1;
            last           = 1'b0;
          end else if (w_s3) begin
            word.bus_sel  = BUS_MEM;
            word.reg_b_in = 1'b1;
            last          = 1'b0;
          end else if (w_s4) begin
            word.bus_sel  = BUS_ALU;
            word.reg_a_in = 1'b1;
            word.flags_in = 1'b1;
            word.alu_op   = (w_op == OP_SUB) ? ALU_SUB : ALU_ADD;
          end
        end
        OP_LDI: begin
          if (w_s2) begin
            word.bus_sel  = BUS_IR;
            word.reg_a_in = 1'b1;
          end
        end
        OP_JMP, OP_JC, OP_JZ: begin
          // Conditional jumps not taken produce an entirely empty step.
          if (w_s2 && ((w_op == OP_JMP) || (w_op == OP_JC && carry_flag) ||
                       (w_op == OP_JZ && zero_flag))) begin
            word.bus_sel = BUS_IR;
            word.pc_in   = 1'b1;
          end
        end
        OP_SLL, OP_SRL: begin
          if (w_s2) begin
            word.bus_sel  = BUS_ALU;
            word.reg_a_in = 1'b1;
            word.flags_in = 1'b1;
            word.alu_op   = (w_op == OP_SRL) ? ALU_SRL : ALU_SLL;
          end
        end
        OP_OUT: begin
          if (w_s2) begin
            word.bus_sel = BUS_A;
            word.out_in  = 1'b1;
          end
        end
        OP_HLT: halt = w_s2;
        default: illegal = w_s2;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/microseq_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | microseq_control : step counter, halt latch, wait-state stall and output   |
// |                    register around the microcode ROM.  Rev 1.0             |
// +----------------------------------------------------------------------------+
module microseq_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int STEP_W    = 3,
  parameter int MAX_STEPS = 6,
  parameter int BUS_SEL_W = 4,
  parameter int ALU_OP_W  = 2
) (
  input  logic                clock,
  input  logic                bReset,
  microseq_control_if.slave   bus
);

  ctrl_word_t        r_word;
  logic [STEP_W-1:0] r_step;
  logic              r_last;
  logic              r_halted;
  logic              r_illegal;

  logic [STEP_W-1:0] w_next_step;
  logic              w_stall;
  logic              w_guard;
  ctrl_word_t        w_rom_word;
  logic              w_rom_last;
  logic              w_rom_halt;
  logic              w_rom_illegal;

  // r_last also marks "restart at fetch" after reset, halt-exit and overrun.
  assign w_next_step = r_last ? '0 : r_step + STEP_W'(1);
  assign w_stall     = (r_word.bus_sel == BUS_MEM) && !bus.mem_ready;
  assign w_guard     = !r_last && ((int'(r_step) + 1) >= MAX_STEPS);

  microcode_rom #(
    .OPCODE_W (OPCODE_W),
    .STEP_W   (STEP_W)
  ) u_rom (
    .opcode     (bus.instruction),
    .step       (w_next_step),
    .carry_flag (bus.carry_flag),
    .zero_flag  (bus.zero_flag),
    .word       (w_rom_word),
    .last       (w_rom_last),
    .halt       (w_rom_halt),
    .illegal    (w_rom_illegal)
  );

  always_ff @(negedge clock) begin
    if (!bReset) begin
      r_word    <= CTRL_IDLE;
      r_step    <= '0;
      r_last    <= 1'b1;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_halted) begin
      r_word    <= CTRL_IDLE;
      r_step    <= '0;
      r_illegal <= 1'b0;
    end else if (w_stall) begin
      r_illegal <= 1'b0;
    end else if (w_guard || w_rom_halt) begin
      r_word    <= CTRL_IDLE;
      r_step    <= '0;
      r_last    <= 1'b1;
      r_halted  <= w_rom_halt && !w_guard;
      r_illegal <= 1'b0;
    end else begin
      r_word    <= w_rom_word;
      r_step    <= w_next_step;
      r_last    <= w_rom_last;
      r_illegal <= w_rom_illegal;
    end
  end

  assign bus.hlt            = r_halted;
  assign bus.memory_in      = r_word.memory_in;
  assign bus.ram_in         = r_word.ram_in;
  assign bus.instruction_in = r_word.instruction_in;
  assign bus.reg_a_in       = r_word.reg_a_in;
  assign bus.reg_b_in       = r_word.reg_b_in;
  assign bus.alu_op         = ALU_OP_W'(r_word.alu_op);
  assign bus.out_in         = r_word.out_in;
  assign bus.advance_pc     = r_word.advance_pc;
  assign bus.pc_in          = r_word.pc_in;
  assign bus.flags_in       = r_word.flags_in;
  assign bus.bus_selector   = BUS_SEL_W'(r_word.bus_sel);
  assign bus.step           = r_step;
  assign bus.illegal_op     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_microseq_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_microseq_control : directed self-checking bench for microseq_control.   |
// |                       Rev 1.0                                              |
// +----------------------------------------------------------------------------+
module tb_microseq_control;

  // Strobe bit order: hlt,memory_in,ram_in,instruction_in,reg_a_in,reg_b_in,
  // out_in,advance_pc,pc_in,flags_in,illegal_op
  localparam logic [10:0] S_NONE  = 11'h000;
  localparam logic [10:0] S_HLT   = 11'h400;
  localparam logic [10:0] S_MEMIN = 11'h200;
  localparam logic [10:0] S_RAM   = 11'h100;
  localparam logic [10:0] S_IRIN  = 11'h080;
  localparam logic [10:0] S_RA    = 11'h040;
  localparam logic [10:0] S_RB    = 11'h020;
  localparam logic [10:0] S_OUT   = 11'h010;
  localparam logic [10:0] S_ADV   = 11'h008;
  localparam logic [10:0] S_PCIN  = 11'h004;
  localparam logic [10:0] S_FLG   = 11'h002;
  localparam logic [10:0] S_ILL   = 11'h001;

  logic clock = 1'b1;
  logic bReset;
  int   tests = 0;
  int   fails = 0;

  microseq_control_if m ();

  microseq_control dut (
    .clock  (clock),
    .bReset (bReset),
    .bus    (m)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [2:0] st,
                             input logic [3:0] bsel, input logic [1:0] alu,
                             input logic [10:0] strobes);
    logic [19:0] obs, exp;
    obs = {m.step, m.bus_selector, m.alu_op, m.hlt, m.memory_in, m.ram_in,
           m.instruction_in, m.reg_a_in, m.reg_b_in, m.out_in, m.advance_pc,
           m.pc_in, m.flags_in, m.illegal_op};
    exp = {st, bsel, alu, strobes};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  task automatic expect_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic fetch_to_s1(input string tag);
    tick(); expect_word({tag, "_s1"}, 3'd1, 4'd5, 2'b00, S_IRIN | S_ADV);
  endtask

  initial begin
    bReset        = 1'b0;
    m.instruction = 4'b0001;
    m.carry_flag  = 1'b0;
    m.zero_flag   = 1'b0;
    m.mem_ready   = 1'b1;

    tick(); expect_word("reset", 3'd0, 4'd0, 2'b00, S_NONE);
    bReset = 1'b1;

    // LDA: 0,1,2,3 then back to 0
    tick(); expect_word("lda_s0", 3'd0, 4'd1, 2'b00, S_MEMIN);
    fetch_to_s1("lda");
    tick(); expect_word("lda_s2", 3'd2, 4'd6, 2'b00, S_MEMIN);
    tick(); expect_word("lda_s3", 3'd3, 4'd5, 2'b00, S_RA);
    tick(); expect_word("lda_end", 3'd0, 4'd1, 2'b00, S_MEMIN);

    // ADD with two wait states in step 3
    m.instruction = 4'b0010;
    fetch_to_s1("add");
    tick(); expect_word("add_s2", 3'd2, 4'd6, 2'b00, S_MEMIN);
    tick(); expect_word("add_s3", 3'd3, 4'd5, 2'b00, S_RB);
    m.mem_ready = 1'b0;
    tick(); expect_word("add_wait1", 3'd3, 4'd5, 2'b00, S_RB);
    tick(); expect_word("add_wait2", 3'd3, 4'd5, 2'b00, S_RB);
    m.mem_ready = 1'b1;
    tick(); expect_word("add_s4", 3'd4, 4'd3, 2'b00, S_RA | S_FLG);
    tick(); expect_word("add_end", 3'd0, 4'd1, 2'b00, S_MEMIN);

    // SRL; mem_ready low during step 0 must not stall
    m.instruction = 4'b1010;
    m.mem_ready   = 1'b0;
    fetch_to_s1("srl");
    m.mem_ready   = 1'b1;
    tick(); expect_word("srl_s2", 3'd2, 4'd3, 2'b11, S_RA | S_FLG);
    tick(); expect_word("srl_end", 3'd0, 4'd1, 2'b00, S_MEMIN);

    // SUB: alu_op 01
    m.instruction = 4'b0011;
    fetch_to_s1("sub");
    tick(); tick();
    tick(); expect_word("sub_s4", 3'd4, 4'd3, 2'b01, S_RA | S_FLG);
    tick(); expect_word("sub_end", 3'd0, 4'd1, 2'b00, S_MEMIN);

    // JZ not taken, then taken
    m.instruction = 4'b1000;
    fetch_to_s1("jz0");
    tick(); expect_bit("jz0_pc_in", m.pc_in, 1'b0);
    expect_bit("jz0_step2", m.step == 3'd2, 1'b1);
    tick(); expect_word("jz0_end", 3'd0, 4'd1, 2'b00, S_MEMIN);
    m.zero_flag = 1'b1;
    fetch_to_s1("jz1");
    tick(); expect_word("jz1_s2", 3'd2, 4'd6, 2'b00, S_PCIN);
    tick(); expect_word("jz1_end", 3'd0, 4'd1, 2'b00, S_MEMIN);

    // JC must look at carry, not zero
    m.instruction = 4'b0111;
    fetch_to_s1("jc0");
    tick(); expect_bit("jc0_pc_in", m.pc_in, 1'b0);
    tick(); expect_word("jc0_end", 3'd0, 4'd1, 2'b00, S_MEMIN);
    m.zero_flag = 1'b0;

    // STA and OUT
    m.instruction = 4'b0100;
    fetch_to_s1("sta");
    tick(); expect_word("sta_s2", 3'd2, 4'd6, 2'b00, S_MEMIN);
    tick(); expect_word("sta_s3", 3'd3, 4'd2, 2'b00, S_RAM);
    tick(); expect_word("sta_end", 3'd0, 4'd1, 2'b00, S_MEMIN);
    m.instruction = 4'b1110;
    fetch_to_s1("out");
    tick(); expect_word("out_s2", 3'd2, 4'd2, 2'b00, S_OUT);
    tick(); expect_word("out_end", 3'd0, 4'd1, 2'b00, S_MEMIN);

    // Illegal opcode 1100: one-cycle pulse, no strobes
    m.instruction = 4'b1100;
    fetch_to_s1("ill");
    tick(); expect_word("ill_s2", 3'd2, 4'd0, 2'b00, S_ILL);
    tick(); expect_word("ill_end", 3'd0, 4'd1, 2'b00, S_MEMIN);

    // Reset at step 3 of ADD
    m.instruction = 4'b0010;
    fetch_to_s1("rst_add");
    tick(); tick(); expect_word("rst_add_s3", 3'd3, 4'd5, 2'b00, S_RB);
    bReset = 1'b0;
    tick(); expect_word("rst_mid", 3'd0, 4'd0, 2'b00, S_NONE);
    bReset = 1'b1;
    tick(); expect_word("rst_mid_fetch", 3'd0, 4'd1, 2'b00, S_MEMIN);

    // HLT: sticky for 20 cycles, cleared by reset
    m.instruction = 4'b1111;
    fetch_to_s1("hlt");
    tick(); expect_word("hlt_set", 3'd0, 4'd0, 2'b00, S_HLT);
    m.instruction = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick(); expect_word("hlt_hold", 3'd0, 4'd0, 2'b00, S_HLT);
    end
    bReset = 1'b0;
    tick(); expect_word("hlt_reset", 3'd0, 4'd0, 2'b00, S_NONE);
    bReset = 1'b1;
    tick(); expect_word("hlt_refetch", 3'd0, 4'd1, 2'b00, S_MEMIN);
    fetch_to_s1("post_hlt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/microseq_control.md
Name: microseq_control

Overview:
Parametrised microsequencer that drives the 8-bit bus CPU datapath and generalises the first-generation control unit. It fetches instructions, decodes the opcode and steps through per-instruction micro-steps, producing one control word per step. New behaviour over the previous generation:
- Working SLL/SRL opcodes.
- Memory wait-state handshake.
- Sticky halt.
- Illegal-opcode flag.
- Step-overrun guard.

Parameters:
OPCODE_W, 4, opcode field width; opcodes use the low 4 bits, and any nonzero upper bits make the opcode illegal
STEP_W, 3, micro-step counter width
MAX_STEPS, 6, step count at which the sequence is forced back to fetch; must be <= 2**STEP_W and >= 5
BUS_SEL_W, 4, bus_selector width
ALU_OP_W, 2, alu_op width

Ports:
clock  in  1  system clock; all state updates on the falling edge
bReset  in  1  synchronous active-low reset, sampled on the falling edge of clock
instruction  in  OPCODE_W  opcode field of the instruction register
carry_flag  in  1  latched ALU carry
zero_flag  in  1  latched ALU zero
mem_ready  in  1  memory read data valid; low inserts wait states
hlt  out  1  clock-halt request; sticky
memory_in  out  1  load memory address register from bus
ram_in  out  1  write bus to RAM
instruction_in  out  1  load instruction register
reg_a_in  out  1  load register A
reg_b_in  out  1  load register B
alu_op  out  ALU_OP_W  00 ADD, 01 SUB, 10 SLL, 11 SRL
out_in  out  1  load output register
advance_pc  out  1  increment PC
pc_in  out  1  load PC from bus
flags_in  out  1  latch flags
bus_selector  out  BUS_SEL_W  bus driver: 0 none, 1 PC, 2 A, 3 ALU, 4 B, 5 Memory, 6 IR
step  out  STEP_W  current micro-step, for debug and bench use
illegal_op  out  1  one-cycle pulse when an undefined opcode is decoded

Behaviour:
- Reset (bReset low at a falling edge):
  - step=0, halted state cleared.
  - All control outputs 0, bus_selector=0, illegal_op=0.
  - Reset takes effect mid-instruction, mid-stall and while halted.
- Each falling edge produces one registered control word, valid for the following rising edge. Every signal not listed for a step is 0.
- Fetch:
  - step 0: bus=PC, memory_in.
  - step 1: bus=Memory, instruction_in, advance_pc.
- Execute decode: opcode is sampled when step>=2. Each sequence ends by setting step to 0.
  - NOP 0000: no controls; back to fetch.
  - LDA 0001: s2 bus=IR, memory_in; s3 bus=Memory, reg_a_in.
  - ADD 0010 / SUB 0011: s2 bus=IR, memory_in; s3 bus=Memory, reg_b_in; s4 bus=ALU, reg_a_in, flags_in, alu_op ADD/SUB. flags_in is asserted on the ALU step only.
  - STA 0100: s2 bus=IR, memory_in; s3 bus=A, ram_in.
  - LDI 0101: s2 bus=IR, reg_a_in.
  - JMP 0110: s2 bus=IR, pc_in.
  - JC 0111 / JZ 1000: s2 bus=IR, pc_in only if carry_flag / zero_flag is set at that edge; otherwise an empty step.
  - SLL 1001 / SRL 1010: s2 bus=ALU, reg_a_in, flags_in, alu_op 10/11. Operand is register A.
  - OUT 1110: s2 bus=A, out_in.
  - HLT 1111: sets halted. hlt=1 from then on and is held until reset; step stays 0 and no other controls assert.
  - Other opcodes (1011, 1100, 1101, or nonzero upper bits): treated as NOP and illegal_op pulses for one cycle.
- Wait states:
  - Condition: a falling edge with mem_ready=0 while the current control word has bus_selector=Memory.
  - Effect: the control word and step are held unchanged, so the stall repeats every cycle until mem_ready=1.
  - mem_ready is ignored in all other steps.
- Overrun guard: if step would reach MAX_STEPS, step is forced to 0 with all controls 0. Unreachable with the default microcode; it exists for future longer instructions.
- Latency: instruction cycles including fetch, with no wait states:
  - 3 cycles: NOP, LDI, JMP, JC, JZ, SLL, SRL, OUT.
  - 4 cycles: LDA, STA.
  - 5 cycles: ADD, SUB.
- Widths: step arithmetic wraps modulo 2**STEP_W, but the guard prevents any wrap. alu_op and bus_selector values are zero-extended to their parameter widths.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - opcode constants, including SLL=1001 and SRL=1010;
  - bus-selector enum;
  - ALU-op enum;
  - control-word struct type.
- One sub-module, microcode_rom: combinational lookup (opcode, step, carry_flag, zero_flag) -> control word plus an end-of-sequence bit.
- The top level owns the step counter, halt latch, stall logic and output register.

Test Plan:
- Reset, then LDA 0001 with mem_ready=1 -> steps 0,1,2,3,0. Step 3 word is bus_selector=5, reg_a_in=1, all else 0.
- ADD 0010, mem_ready held 0 for 2 cycles in step 3 -> the step 3 word repeats 3 cycles total. The next word is bus_selector=3, reg_a_in=1, flags_in=1, alu_op=00. Total 7 cycles.
- SRL 1010 -> step 2 word is bus_selector=3, alu_op=11, reg_a_in=1, flags_in=1; the following step is 0.
- JZ 1000 with zero_flag=0, then zero_flag=1 -> pc_in=0 in the first case and pc_in=1 with bus_selector=6 in the second; both take 3 cycles.
- HLT 1111 -> hlt=1 held for 20 cycles with step=0. bReset=0 for one falling edge -> hlt=0, step=0, and the next word is fetch step 0.
- Opcode 1100 -> illegal_op=1 for exactly one cycle, no load strobes, back to fetch after 3 cycles. Separately, bReset asserted at step 3 of ADD -> all outputs 0 at the next falling edge.
